// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode 7-segment
//               display, with frame-synchronous double-buffered contents.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DWELL       = 50000,
    parameter int GAP         = 500,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_blank,
    output logic                  wr_ready,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     digit_n,
    output logic                  frame_done
);

    localparam int c_IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int c_CW   = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;

    localparam logic [c_IW-1:0] c_LAST      = c_IW'(DIGITS - 1);
    localparam logic [c_CW-1:0] c_DWELL_END = c_CW'(DWELL - 1);
    localparam logic [c_CW-1:0] c_GAP_END   = c_CW'(GAP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]            r_state;
    logic [c_IW-1:0]       r_idx;
    logic [c_CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0]   r_act_data;
    logic [DIGITS-1:0]     r_act_blank;
    logic [4*DIGITS-1:0]   r_pend_data;
    logic [DIGITS-1:0]     r_pend_blank;
    logic                  r_pend_valid;

    logic [1:0]            w_state_nxt;
    logic [c_IW-1:0]       w_idx_nxt;
    logic [c_CW-1:0]       w_cnt_nxt;
    logic                  w_frame_end;
    logic                  w_commit;
    logic                  w_accept;
    logic                  w_upper_zero;
    logic                  w_cur_blank;
    logic                  w_suppress;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_act_data   <= '0;
            r_act_blank  <= '1;
            r_pend_data  <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            // Commit and capture are exclusive: capture needs an empty pending buffer.
            if (w_commit) begin
                r_act_data   <= r_pend_data;
                r_act_blank  <= r_pend_blank;
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_pend_data  <= wr_data;
                r_pend_blank <= wr_blank;
                r_pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_ON;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            S_ON: begin
                if (r_cnt == c_DWELL_END) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_END) begin
                    w_cnt_nxt = '0;
                    if (r_idx == c_LAST) begin
                        w_frame_end = 1'b1;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + c_IW'(1);
                    end
                    if (enable) begin
                        w_state_nxt = S_ON;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_commit   = r_pend_valid && (w_frame_end || (r_state == S_IDLE));
    assign w_accept   = wr && !r_pend_valid;
    assign wr_ready   = !r_pend_valid;
    assign frame_done = w_frame_end;

    always_comb begin
        nibble       = 4'h0;
        w_cur_blank  = 1'b0;
        w_upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IW'(i)) begin
                nibble      = r_act_data[4*i +: 4];
                w_cur_blank = r_act_blank[i];
            end
            // Leading-zero test covers the current digit and everything above it.
            if ((c_IW'(i) >= r_idx) && (r_act_data[4*i +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_suppress = (LZ_SUPPRESS != 0) && (r_idx != '0) && w_upper_zero;

    always_comb begin
        digit_n = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((r_state == S_ON) && (r_idx == c_IW'(i)) && !w_cur_blank && !w_suppress) begin
                digit_n[i] = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
